// File: rtl/pipe_pkg.sv
// Shared types and control-bit indices for the elastic pipeline stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  localparam int CTRL_PCSRC    = 0;
  localparam int CTRL_REGW     = 1;
  localparam int CTRL_MEMW     = 2;
  localparam int CTRL_MEMTOREG = 3;

endpackage

// File: rtl/pipe_entry_reg.sv
// Load-enabled register holding one packed {ctrl, wa, data} pipeline entry.
module pipe_entry_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] entry_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      entry_reg <= '0;
    end else if (load) begin
      entry_reg <= d;
    end
  end

  assign q = entry_reg;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register: valid/ready handshake, optional skid entry,
// synchronous flush, bubble-gated control bits and a saturating stall counter.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_DATA = 2,
  parameter int RA_W     = 4,
  parameter int CTRL_W   = 4,
  parameter int SKID     = 1,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [RA_W-1:0]            in_wa,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [RA_W-1:0]            out_wa,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int ENTRY_W = CTRL_W + RA_W + NUM_DATA * DATA_W;

  occ_e state_reg, state_next;
  logic main_load, skid_load, main_from_skid;
  logic accept, take;
  logic [ENTRY_W-1:0] in_entry, main_d, main_q, skid_q;
  logic [CTRL_W-1:0]  main_ctrl;
  logic [CNT_W-1:0]   stall_cnt_reg;

  assign in_entry  = {in_ctrl, in_wa, in_data};
  assign out_valid = (state_reg != OCC_EMPTY);
  assign accept    = in_valid & in_ready;
  assign take      = out_valid & out_ready;

  // With a skid entry, in_ready depends only on registered state.
  if (SKID != 0) begin : g_ready_skid
    assign in_ready = reset & (state_reg != OCC_FULL);
  end else begin : g_ready_pass
    assign in_ready = reset & (~out_valid | out_ready);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= OCC_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_next = OCC_EMPTY;
    end else begin
      case (state_reg)
        OCC_EMPTY: begin
          if (accept) begin
            state_next = OCC_ONE;
            main_load  = 1'b1;
          end
        end
        OCC_ONE: begin
          if (accept && take) begin
            main_load = 1'b1;
          end else if (accept && SKID != 0) begin
            state_next = OCC_FULL;
            skid_load  = 1'b1;
          end else if (take) begin
            state_next = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (take) begin
            state_next     = OCC_ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_next = OCC_EMPTY;
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : in_entry;

  pipe_entry_reg #(.W(ENTRY_W)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  if (SKID != 0) begin : g_skid
    pipe_entry_reg #(.W(ENTRY_W)) u_skid (
      .clk   (clk),
      .reset (reset),
      .load  (skid_load),
      .d     (in_entry),
      .q     (skid_q)
    );
  end else begin : g_no_skid
    logic unused_skid_load;
    assign unused_skid_load = skid_load;
    assign skid_q           = '0;
  end

  assign {main_ctrl, out_wa, out_data} = main_q;
  // Bubbles must never carry live control bits downstream.
  assign out_ctrl = out_valid ? main_ctrl : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_reg <= '0;
    end else if (out_valid && !out_ready && stall_cnt_reg != '1) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: SKID=1 (CNT_W=4) and SKID=0 instances,
// observed through a shared selector.
module tb_pipe_stage_elastic;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, in_valid, out_ready;
  logic [3:0]  in_ctrl, in_wa;
  logic [63:0] in_data;

  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [3:0]  a_out_ctrl, a_out_wa, b_out_ctrl, b_out_wa;
  logic [63:0] a_out_data, b_out_data;
  logic [3:0]  a_stall_cnt;
  logic [15:0] b_stall_cnt;

  logic        sel = 1'b0;
  int          errors = 0;
  int          checks = 0;

  pipe_stage_elastic #(.SKID(1), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .in_ctrl(in_ctrl), .in_wa(in_wa), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_ctrl(a_out_ctrl), .out_wa(a_out_wa), .out_data(a_out_data),
    .stall_cnt(a_stall_cnt)
  );

  pipe_stage_elastic #(.SKID(0), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .in_ctrl(in_ctrl), .in_wa(in_wa), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_ctrl(b_out_ctrl), .out_wa(b_out_wa), .out_data(b_out_data),
    .stall_cnt(b_stall_cnt)
  );

  logic        o_ready, o_valid;
  logic [3:0]  o_ctrl, o_wa;
  logic [63:0] o_data;
  logic [15:0] o_stall;

  assign o_ready = sel ? b_in_ready  : a_in_ready;
  assign o_valid = sel ? b_out_valid : a_out_valid;
  assign o_ctrl  = sel ? b_out_ctrl  : a_out_ctrl;
  assign o_wa    = sel ? b_out_wa    : a_out_wa;
  assign o_data  = sel ? b_out_data  : a_out_data;
  assign o_stall = sel ? b_stall_cnt : 16'(a_stall_cnt);

  function automatic logic [63:0] mk(input logic [31:0] w1, input logic [31:0] w0);
    return {w1, w0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [3:0] wa, input logic [63:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_wa    = wa;
    in_data  = d;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 4'h0, 64'h0);
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [3:0] c, input logic [3:0] wa, input logic [63:0] d);
    chk({tag, "_valid"}, 64'(o_valid), 64'(1'b1));
    chk({tag, "_ctrl"},  64'(o_ctrl),  64'(c));
    chk({tag, "_wa"},    64'(o_wa),    64'(wa));
    chk({tag, "_data"},  o_data, d);
    $display("[%0t] %s head ctrl=%h wa=%h data=%h", $time, tag, o_ctrl, o_wa, o_data);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"},  64'(o_ready), 64'(1'b0));
    chk({tag, "_out_valid"}, 64'(o_valid), 64'(1'b0));
    chk({tag, "_out_ctrl"},  64'(o_ctrl),  64'h0);
    chk({tag, "_out_wa"},    64'(o_wa),    64'h0);
    chk({tag, "_out_data"},  o_data,       64'h0);
    chk({tag, "_stall"},     64'(o_stall), 64'h0);
  endtask

  task automatic run_stream(input string tag);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1'b1, 4'h2, 4'(i + 1), mk(32'(i + 1), 32'('hA + i)));
      else idle();
      at_neg();
      chk({tag, "_rdy"}, 64'(o_ready), 64'(1'b1));
      if (i == 0) chk({tag, "_first_empty"}, 64'(o_valid), 64'(1'b0));
      else chk_head(tag, 4'h2, 4'(i), mk(32'(i), 32'('hA + i - 1)));
      next();
    end
    at_neg();
    chk({tag, "_end_valid"}, 64'(o_valid), 64'(1'b0));
    chk({tag, "_end_ctrl"},  64'(o_ctrl),  64'h0);
    chk({tag, "_end_hold"},  o_data, mk(32'h3, 32'hC));
    chk({tag, "_end_stall"}, 64'(o_stall), 64'h0);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 4'hF, 4'hF, mk(32'h9, 32'h9));

    // Reset with in_valid asserted
    repeat (3) next();
    at_neg();
    chk_reset("a_reset");
    reset = 1'b1;
    idle();
    at_neg();
    chk("a_rdy_after_reset", 64'(o_ready), 64'(1'b1));
    next();

    run_stream("a_stream");
    next();

    // Backpressure through the skid entry
    out_ready = 1'b0;
    drive(1'b1, 4'h4, 4'h8, mk(32'h100, 32'h200));
    at_neg(); chk("bp_c0_rdy", 64'(o_ready), 64'(1'b1)); chk("bp_c0_valid", 64'(o_valid), 64'(1'b0)); next();
    drive(1'b1, 4'h4, 4'h9, mk(32'h101, 32'h201));
    at_neg(); chk("bp_c1_rdy", 64'(o_ready), 64'(1'b1)); chk_head("bp_c1", 4'h4, 4'h8, mk(32'h100, 32'h200)); next();
    drive(1'b1, 4'h4, 4'hA, mk(32'h102, 32'h202));
    at_neg(); chk("bp_c2_rdy", 64'(o_ready), 64'(1'b0)); chk_head("bp_c2", 4'h4, 4'h8, mk(32'h100, 32'h200));
    chk("bp_c2_stall", 64'(o_stall), 64'd1); next();
    at_neg(); chk("bp_c3_rdy", 64'(o_ready), 64'(1'b0)); chk("bp_c3_stall", 64'(o_stall), 64'd2); next();
    out_ready = 1'b1;
    at_neg(); chk("bp_c4_rdy", 64'(o_ready), 64'(1'b0)); chk_head("bp_c4", 4'h4, 4'h8, mk(32'h100, 32'h200));
    chk("bp_c4_stall", 64'(o_stall), 64'd3); next();
    at_neg(); chk("bp_c5_rdy", 64'(o_ready), 64'(1'b1)); chk_head("bp_c5", 4'h4, 4'h9, mk(32'h101, 32'h201)); next();
    idle();
    at_neg(); chk_head("bp_c6", 4'h4, 4'hA, mk(32'h102, 32'h202)); next();
    at_neg(); chk("bp_c7_valid", 64'(o_valid), 64'(1'b0)); chk("bp_c7_stall", 64'(o_stall), 64'd3); next();

    // Flush from FULL, then flush from ONE with a live accept
    out_ready = 1'b0;
    drive(1'b1, 4'h2, 4'h1, mk(32'h5, 32'h5)); next();
    drive(1'b1, 4'h2, 4'h2, mk(32'h5, 32'h6)); next();
    flush = 1'b1;
    drive(1'b1, 4'b0010, 4'h4, mk(32'h6, 32'h6));
    at_neg(); chk("fl_full_rdy", 64'(o_ready), 64'(1'b0)); next();
    flush = 1'b0;
    idle();
    at_neg(); chk("fl1_valid", 64'(o_valid), 64'(1'b0)); chk("fl1_ctrl", 64'(o_ctrl), 64'h0);
    chk("fl1_rdy", 64'(o_ready), 64'(1'b1)); next();
    drive(1'b1, 4'b0110, 4'h3, mk(32'h7, 32'h7)); next();
    flush = 1'b1;
    drive(1'b1, 4'b0010, 4'h4, mk(32'h8, 32'h8));
    at_neg(); chk("fl_one_rdy", 64'(o_ready), 64'(1'b1)); chk_head("fl_one", 4'b0110, 4'h3, mk(32'h7, 32'h7)); next();
    flush = 1'b0;
    idle();
    at_neg(); chk("fl2_valid", 64'(o_valid), 64'(1'b0)); chk("fl2_ctrl", 64'(o_ctrl), 64'h0);
    chk("fl2_stall", 64'(o_stall), 64'd6); next();
    at_neg(); chk("fl3_valid", 64'(o_valid), 64'(1'b0)); chk("fl3_hold", o_data, mk(32'h7, 32'h7)); next();

    // Bubble gating of control bits
    out_ready = 1'b1;
    drive(1'b1, 4'hF, 4'h5, mk(32'hB, 32'hB)); next();
    idle();
    at_neg(); chk_head("bub", 4'hF, 4'h5, mk(32'hB, 32'hB)); next();
    at_neg(); chk("bub_valid", 64'(o_valid), 64'(1'b0)); chk("bub_ctrl", 64'(o_ctrl), 64'h0);
    chk("bub_wa_hold", 64'(o_wa), 64'h5); next();

    // Stall counter saturation (4-bit counter, already at 6)
    out_ready = 1'b0;
    drive(1'b1, 4'h1, 4'h6, mk(32'hC, 32'hC)); next();
    idle();
    repeat (20) next();
    at_neg(); chk("sat_stall", 64'(o_stall), 64'hF); chk_head("sat", 4'h1, 4'h6, mk(32'hC, 32'hC));
    out_ready = 1'b1; next();
    at_neg(); chk("sat_drain_valid", 64'(o_valid), 64'(1'b0)); chk("sat_hold", 64'(o_stall), 64'hF); next();

    // SKID=0 instance
    sel = 1'b1;
    reset = 1'b0; out_ready = 1'b0;
    drive(1'b1, 4'hF, 4'hF, mk(32'h9, 32'h9));
    repeat (2) next();
    at_neg(); chk_reset("b_reset");
    reset = 1'b1;
    idle();
    at_neg(); chk("b_rdy_after_reset", 64'(o_ready), 64'(1'b1)); next();
    run_stream("b_stream");
    next();

    out_ready = 1'b0;
    drive(1'b1, 4'h4, 4'h8, mk(32'h100, 32'h200));
    at_neg(); chk("b_bp_c0_rdy", 64'(o_ready), 64'(1'b1)); chk("b_bp_c0_valid", 64'(o_valid), 64'(1'b0)); next();
    drive(1'b1, 4'h4, 4'h9, mk(32'h101, 32'h201));
    at_neg(); chk("b_bp_c1_rdy", 64'(o_ready), 64'(1'b0)); chk_head("b_bp_c1", 4'h4, 4'h8, mk(32'h100, 32'h200)); next();
    at_neg(); chk("b_bp_c2_rdy", 64'(o_ready), 64'(1'b0)); chk("b_bp_c2_stall", 64'(o_stall), 64'd1); next();
    out_ready = 1'b1;
    at_neg(); chk("b_bp_c3_rdy", 64'(o_ready), 64'(1'b1)); chk_head("b_bp_c3", 4'h4, 4'h8, mk(32'h100, 32'h200));
    chk("b_bp_c3_stall", 64'(o_stall), 64'd2); next();
    drive(1'b1, 4'h4, 4'hA, mk(32'h102, 32'h202));
    at_neg(); chk("b_bp_c4_rdy", 64'(o_ready), 64'(1'b1)); chk_head("b_bp_c4", 4'h4, 4'h9, mk(32'h101, 32'h201)); next();
    idle();
    at_neg(); chk_head("b_bp_c5", 4'h4, 4'hA, mk(32'h102, 32'h202)); next();
    at_neg(); chk("b_bp_c6_valid", 64'(o_valid), 64'(1'b0)); chk("b_bp_c6_stall", 64'(o_stall), 64'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
